// File: rtl/serial_transmit.sv
// Parallel-to-serial framer: start 0, WIDTH data bits LSB first, stop 1, each bit SAMPLES clocks.
// Optional even-parity bit before stop when SERIAL_TX_PARITY_EN is defined.
module serial_transmit #(
  parameter int SAMPLES = 16,
  parameter int WIDTH   = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_data_in,
  input  logic             i_load,
  output logic             o_data_out,
  output logic             o_busy,
  output logic             o_done
);

  localparam int CW = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(SAMPLES - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  // IDLE line high | START line 0 | DATA r_data[r_bit] | PARITY ^r_data | STOP line 1
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef SERIAL_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [BW-1:0]    r_bit;
  logic [BW-1:0]    w_bit_nxt;
  logic [WIDTH-1:0] r_data;
  logic             r_data_out;
  logic             w_line_nxt;
  logic             w_wrap;

  assign w_wrap = (r_cnt == LAST_CNT);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_data     <= '0;
      r_data_out <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= (r_state == S_IDLE || w_wrap) ? '0 : r_cnt + CW'(1);
      r_bit      <= w_bit_nxt;
      r_data_out <= w_line_nxt;
      if (r_state == S_IDLE && i_load) begin
        r_data <= i_data_in;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_bit_nxt   = '0;
    case (r_state)
      S_IDLE: begin
        if (i_load) w_state_nxt = S_START;
      end
      S_START: begin
        if (w_wrap) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        w_bit_nxt = r_bit;
        if (w_wrap) begin
          if (r_bit == LAST_BIT) begin
            w_bit_nxt = '0;
`ifdef SERIAL_TX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end else begin
            w_bit_nxt = r_bit + BW'(1);
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      S_PARITY: begin
        if (w_wrap) w_state_nxt = S_STOP;
      end
`endif
      S_STOP: begin
        if (w_wrap) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Line level is computed for the upcoming state so data_out stays a plain register.
  always_comb begin
    w_line_nxt = 1'b1;
    case (w_state_nxt)
      S_START:  w_line_nxt = 1'b0;
      S_DATA:   w_line_nxt = r_data[w_bit_nxt];
`ifdef SERIAL_TX_PARITY_EN
      S_PARITY: w_line_nxt = ^r_data;
`endif
      default:  w_line_nxt = 1'b1;
    endcase
  end

  assign o_data_out = r_data_out;
  assign o_busy     = (r_state != S_IDLE);
  assign o_done     = (r_state == S_STOP) && w_wrap;

endmodule

// File: tb/tb_serial_transmit.sv
// Self-checking bench for serial_transmit; model tracks cycles since accept and derives the line from frame bit order.
// Define SERIAL_TX_PARITY_EN for both bench and RTL to cover the parity build.
module tb_serial_transmit;
  localparam int S = 16;
  localparam int W = 8;
`ifdef SERIAL_TX_PARITY_EN
  localparam int F   = (W + 3) * S;
  localparam bit PAR = 1'b1;
`else
  localparam int F   = (W + 2) * S;
  localparam bit PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [7:0] data_in;
  logic       data_out;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  serial_transmit #(.SAMPLES(S), .WIDTH(W)) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_data_in  (data_in),
    .i_load     (load),
    .o_data_out (data_out),
    .o_busy     (busy),
    .o_done     (done)
  );

  int n_checks = 0;
  int n_err    = 0;
  int m_k      = -1;  // cycles since accept (1..F while framing), -1 when idle
  logic [7:0] m_byte = '0;

  function automatic logic exp_line(int k, logic [7:0] b);
    int idx;
    if (k < 1) return 1'b1;
    idx = (k - 1) / S;
    if (idx == 0) return 1'b0;
    if (idx <= W) return b[3'(idx - 1)];
    if (PAR && idx == W + 1) return ^b;
    return 1'b1;
  endfunction

  task automatic tick();
    if (reset) m_k = -1;
    else if (m_k < 1) begin
      if (load) begin
        m_k    = 1;
        m_byte = data_in;
      end
    end else m_k = (m_k == F) ? -1 : m_k + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; load = 1'b0; data_in = 8'h00;
    for (int c = 0; c < 6; c++) begin
      if (c == 2) reset = 1'b0;
      tick();
      n_checks++; if (data_out !== 1'b1) begin n_err++; $display("FAIL reset_line c=%0d got=%b exp=1", c, data_out); end
      n_checks++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy c=%0d got=%b exp=0", c, busy); end
      n_checks++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done c=%0d got=%b exp=0", c, done); end
    end
  endtask

  task automatic test_frame(input logic [7:0] b);
    int done_at = -1;
    load = 1'b1; data_in = b;
    for (int c = 1; c <= F + 4; c++) begin
      tick();
      load = 1'b0; data_in = 8'($urandom);
      if (done) done_at = c;
      n_checks++; if (data_out !== exp_line(m_k, m_byte)) begin n_err++; $display("FAIL frame_line b=%h c=%0d got=%b exp=%b", b, c, data_out, exp_line(m_k, m_byte)); end
      n_checks++; if (busy !== (m_k >= 1)) begin n_err++; $display("FAIL frame_busy b=%h c=%0d got=%b exp=%b", b, c, busy, m_k >= 1); end
`ifdef SERIAL_TX_PARITY_EN
      if (c == (W + 1) * S + 1) begin
        n_checks++; if (data_out !== ^b) begin n_err++; $display("FAIL parity_bit b=%h got=%b exp=%b", b, data_out, ^b); end
      end
`endif
    end
    n_checks++; if (done_at != F) begin n_err++; $display("FAIL frame_done_at b=%h got=%0d exp=%0d", b, done_at, F); end
  endtask

  task automatic test_drop_while_busy();
    int n_done = 0;
    load = 1'b1; data_in = 8'hA5;
    for (int c = 1; c <= F + 8; c++) begin
      tick();
      load = (c == 50); data_in = (c == 50) ? 8'h3C : 8'($urandom);
      if (done) n_done++;
      n_checks++; if (data_out !== exp_line(m_k, m_byte)) begin n_err++; $display("FAIL drop_line c=%0d got=%b exp=%b", c, data_out, exp_line(m_k, m_byte)); end
      n_checks++; if (busy !== (m_k >= 1)) begin n_err++; $display("FAIL drop_busy c=%0d got=%b exp=%b", c, busy, m_k >= 1); end
    end
    n_checks++; if (n_done != 1) begin n_err++; $display("FAIL drop_done_count got=%0d exp=1", n_done); end
  endtask

  task automatic test_back_to_back();
    int d0 = -1, d1 = -1, start2 = -1;
    load = 1'b1; data_in = 8'h01;
    for (int c = 1; c <= 2 * F + 6; c++) begin
      tick();
      if (c == 1) data_in = 8'hFF;
      if (c == 2 * F + 1) load = 1'b0;
      if (done) begin if (d0 < 0) d0 = c; else d1 = c; end
      if (c > F + 1 && start2 < 0 && data_out === 1'b0) start2 = c;
      n_checks++; if (data_out !== exp_line(m_k, m_byte)) begin n_err++; $display("FAIL b2b_line c=%0d got=%b exp=%b", c, data_out, exp_line(m_k, m_byte)); end
      n_checks++; if (done !== (m_k == F)) begin n_err++; $display("FAIL b2b_done c=%0d got=%b exp=%b", c, done, m_k == F); end
    end
    n_checks++; if (d0 != F || d1 != 2 * F + 1) begin n_err++; $display("FAIL b2b_done_at got=%0d,%0d exp=%0d,%0d", d0, d1, F, 2 * F + 1); end
    n_checks++; if (start2 != F + 2) begin n_err++; $display("FAIL b2b_start2 got=%0d exp=%0d", start2, F + 2); end
  endtask

  task automatic test_reset_abort();
    int done_at = -1;
    load = 1'b1; data_in = 8'hA5;
    for (int c = 1; c <= 75 + F + 4; c++) begin
      tick();
      load = (c == 75); reset = (c == 70);
      data_in = (c == 75) ? 8'h55 : 8'($urandom);
      if (done) done_at = c;
      n_checks++; if (data_out !== exp_line(m_k, m_byte)) begin n_err++; $display("FAIL abort_line c=%0d got=%b exp=%b", c, data_out, exp_line(m_k, m_byte)); end
      n_checks++; if (busy !== (m_k >= 1)) begin n_err++; $display("FAIL abort_busy c=%0d got=%b exp=%b", c, busy, m_k >= 1); end
    end
    n_checks++; if (done_at != 75 + F) begin n_err++; $display("FAIL abort_done_at got=%0d exp=%0d", done_at, 75 + F); end
  endtask

  task automatic test_random();
    for (int c = 1; c <= 4000; c++) begin
      reset = ($urandom_range(0, 599) == 0);
      load  = ($urandom_range(0, 3) != 0);
      data_in = 8'($urandom);
      tick();
      n_checks++; if (data_out !== exp_line(m_k, m_byte)) begin n_err++; $display("FAIL rand_line c=%0d got=%b exp=%b", c, data_out, exp_line(m_k, m_byte)); end
      n_checks++; if (busy !== (m_k >= 1)) begin n_err++; $display("FAIL rand_busy c=%0d got=%b exp=%b", c, busy, m_k >= 1); end
      n_checks++; if (done !== (m_k == F)) begin n_err++; $display("FAIL rand_done c=%0d got=%b exp=%b", c, done, m_k == F); end
    end
    reset = 1'b0; load = 1'b0;
    for (int c = 0; c < F + 2; c++) tick();
  endtask

  initial begin
    test_reset();
    test_frame(8'hA5);
    test_frame(8'h00);
    test_frame(8'hFF);
    test_frame(8'h5A);
`ifdef SERIAL_TX_PARITY_EN
    test_frame(8'h07);
`endif
    test_drop_while_busy();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
